// File: rtl/game_io_pkg.sv
// rtl/game_io_pkg.sv - shared key codes, clock rate, debounce/repeat defaults
package game_io_pkg;

    localparam int unsigned CLK_FREQ_HZ         = 50_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_FREQ_HZ / 50;
    localparam int unsigned REPEAT_DELAY_DEF    = CLK_FREQ_HZ / 2;
    localparam int unsigned REPEAT_PERIOD_DEF   = CLK_FREQ_HZ / 10;
    localparam int unsigned CNT_W_DEF           = 26;

    typedef enum logic [1:0] {
        KEY_NONE = 2'd0,
        KEY_1    = 2'd1,
        KEY_2    = 2'd2,
        KEY_3    = 2'd3
    } key_code_e;

    typedef enum logic [1:0] {
        REP_IDLE   = 2'd0,
        REP_DELAY  = 2'd1,
        REP_PERIOD = 2'd2
    } rep_state_e;

endpackage

// File: rtl/key_event_reader_if.sv
// rtl/key_event_reader_if.sv - valid/ready key event port
interface key_event_reader_if;

    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_code;
    logic       evt_repeat;

    modport master (output evt_valid, output evt_code, output evt_repeat, input evt_ready);
    modport slave  (input evt_valid, input evt_code, input evt_repeat, output evt_ready);

endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchroniser, debouncer and hold/repeat timer
module key_debounce
    import game_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic press_pulse,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    rep_state_e       rep_state_q, rep_state_d;
    logic             flip;
    logic [CNT_W-1:0] hold_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            level_q     <= 1'b0;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            rep_state_q <= REP_IDLE;
        end else begin
            sync_q      <= sync_d;
            level_q     <= level_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            rep_state_q <= rep_state_d;
        end
    end

    always_comb begin
        // sync_q[1] is the synchronised sample, inverted so 1 = pressed
        sync_d   = {sync_q[0], ~key_n};
        level_d  = level_q;
        db_cnt_d = '0;
        flip     = 1'b0;
        if (sync_q[1] != level_q) begin
            if (db_cnt_q >= DB_LAST) begin
                flip    = 1'b1;
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        press_pulse = flip & ~level_q;
    end

    always_comb begin
        rep_state_d  = rep_state_q;
        hold_cnt_d   = hold_cnt_q;
        repeat_pulse = 1'b0;
        hold_last    = (rep_state_q == REP_DELAY) ? DELAY_LAST : PERIOD_LAST;
        case (rep_state_q)
            REP_IDLE: begin
                hold_cnt_d = '0;
                if (press_pulse && (REPEAT_EN != 0)) rep_state_d = REP_DELAY;
            end
            REP_DELAY, REP_PERIOD: begin
                // a release landing on the same cycle as a repeat suppresses it
                if (!level_q || flip) begin
                    rep_state_d = REP_IDLE;
                    hold_cnt_d  = '0;
                end else if (hold_cnt_q >= hold_last) begin
                    repeat_pulse = 1'b1;
                    hold_cnt_d   = '0;
                    rep_state_d  = REP_PERIOD;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                rep_state_d = REP_IDLE;
                hold_cnt_d  = '0;
            end
        endcase
    end

    assign level = level_q;

endmodule

// File: rtl/key_event_reader.sv
// rtl/key_event_reader.sv - debounced KEY[3:1] to one-at-a-time press/repeat events
module key_event_reader
    import game_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic                      CLOCK_50,
    input  logic                      KEY0,
    input  logic [2:0]                KEY_IN,
    output logic [2:0]                key_down,
    key_event_reader_if.master        evt,
    output logic                      evt_ovf
);

    logic [2:0] level, press_pulse, repeat_pulse;

    for (genvar i = 0; i < 3; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .CNT_W           (CNT_W)
        ) u_db (
            .clk          (CLOCK_50),
            .rst_n        (KEY0),
            .key_n        (KEY_IN[i]),
            .level        (level[i]),
            .press_pulse  (press_pulse[i]),
            .repeat_pulse (repeat_pulse[i])
        );
    end

    logic [2:0] pend_q, pend_d;
    logic [2:0] pend_rep_q, pend_rep_d;
    logic       valid_q, valid_d;
    logic [1:0] code_q, code_d;
    logic       rep_q, rep_d;
    logic       ovf_q, ovf_d;
    logic [2:0] ev, pick_oh, taken;
    logic [1:0] pick_code;
    logic       load;

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            pend_q     <= '0;
            pend_rep_q <= '0;
            valid_q    <= 1'b0;
            code_q     <= KEY_NONE;
            rep_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_rep_q <= pend_rep_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            rep_q      <= rep_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        ev        = press_pulse | repeat_pulse;
        pick_oh   = 3'b000;
        pick_code = KEY_NONE;
        if (pend_q[0]) begin
            pick_oh   = 3'b001;
            pick_code = KEY_1;
        end else if (pend_q[1]) begin
            pick_oh   = 3'b010;
            pick_code = KEY_2;
        end else if (pend_q[2]) begin
            pick_oh   = 3'b100;
            pick_code = KEY_3;
        end
        load  = (!valid_q || evt.evt_ready) && (pend_q != 3'b000);
        taken = load ? pick_oh : 3'b000;

        // an event arriving as its own pending bit is taken simply re-arms it
        pend_d     = (pend_q & ~taken) | ev;
        pend_rep_d = (ev & repeat_pulse) | (~ev & pend_rep_q);
        ovf_d      = ovf_q | (|(ev & pend_q & ~taken));

        valid_d = valid_q;
        code_d  = code_q;
        rep_d   = rep_q;
        if (load) begin
            valid_d = 1'b1;
            code_d  = pick_code;
            rep_d   = |(pend_rep_q & pick_oh);
        end else if (evt.evt_ready) begin
            valid_d = 1'b0;
        end
    end

    assign key_down       = level;
    assign evt.evt_valid  = valid_q;
    assign evt.evt_code   = code_q;
    assign evt.evt_repeat = rep_q;
    assign evt_ovf        = ovf_q;

endmodule
